// File: rtl/spike_rate_decoder_if.sv
// Spike-train input, window control and valid/ready result bus of the spike rate decoder.
interface spike_rate_decoder_if #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
);
  logic             ena;
  logic             spike_in;
  logic [WIN_W-1:0] window_len;
  logic [CNT_W-1:0] rate_out;
  logic [ISI_W-1:0] isi_out;
  logic             sat;
  logic             rate_valid;
  logic             rate_ready;

  modport master (
    output ena, spike_in, window_len, rate_ready,
    input  rate_out, isi_out, sat, rate_valid
  );

  modport slave (
    input  ena, spike_in, window_len, rate_ready,
    output rate_out, isi_out, sat, rate_valid
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Decodes a 1-bit spike train into a per-window spike count and last inter-spike
// interval, presented on a registered valid/ready result port.
module spike_rate_decoder #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spike_rate_decoder_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ISI_W-1:0] ISI_MAX = '1;
  localparam logic [ISI_W-1:0] GAP_MAX = ISI_MAX - ISI_W'(1);

  state_t           state_q, state_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] spk_cnt_q, spk_cnt_d;
  logic [ISI_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             gap_ovf_q, gap_ovf_d;
  logic [ISI_W-1:0] isi_q, isi_d;
  logic             seen_q, seen_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] rate_o_q, rate_o_d;
  logic [ISI_W-1:0] isi_o_q, isi_o_d;
  logic             sat_o_q, sat_o_d;
  logic             valid_q, valid_d;

  logic             start_ok, do_start;
  logic [CNT_W-1:0] spk_n;
  logic [ISI_W-1:0] gap_n, isi_n;
  logic             gap_ovf_n, seen_n, sat_n;

  assign start_ok = bus.ena && (bus.window_len != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      win_cnt_q <= '0;
      spk_cnt_q <= '0;
      gap_cnt_q <= '0;
      gap_ovf_q <= 1'b0;
      isi_q     <= '0;
      seen_q    <= 1'b0;
      sat_q     <= 1'b0;
      rate_o_q  <= '0;
      isi_o_q   <= '0;
      sat_o_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      win_cnt_q <= win_cnt_d;
      spk_cnt_q <= spk_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      gap_ovf_q <= gap_ovf_d;
      isi_q     <= isi_d;
      seen_q    <= seen_d;
      sat_q     <= sat_d;
      rate_o_q  <= rate_o_d;
      isi_o_q   <= isi_o_d;
      sat_o_q   <= sat_o_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    win_cnt_d = win_cnt_q;
    spk_cnt_d = spk_cnt_q;
    gap_cnt_d = gap_cnt_q;
    gap_ovf_d = gap_ovf_q;
    isi_d     = isi_q;
    seen_d    = seen_q;
    sat_d     = sat_q;
    rate_o_d  = rate_o_q;
    isi_o_d   = isi_o_q;
    sat_o_d   = sat_o_q;
    valid_d   = valid_q;
    do_start  = 1'b0;
    spk_n     = spk_cnt_q;
    gap_n     = gap_cnt_q;
    gap_ovf_n = gap_ovf_q;
    isi_n     = isi_q;
    seen_n    = seen_q;
    sat_n     = sat_q;

    case (state_q)
      S_IDLE: do_start = start_ok;
      S_COUNT: begin
        if (!bus.ena) begin
          state_d = S_IDLE;
        end else begin
          if (bus.spike_in) begin
            if (spk_cnt_q == CNT_MAX) sat_n = 1'b1;
            else                      spk_n = spk_cnt_q + CNT_W'(1);
            if (seen_q) begin
              // gap_ovf means the true gap ran past the counter, so the ISI is clipped
              if (gap_ovf_q) begin
                isi_n = ISI_MAX;
                sat_n = 1'b1;
              end else begin
                isi_n = gap_cnt_q + ISI_W'(1);
              end
            end
            gap_n     = '0;
            gap_ovf_n = 1'b0;
            seen_n    = 1'b1;
          end else if (seen_q) begin
            if (gap_cnt_q == GAP_MAX) gap_ovf_n = 1'b1;
            else                      gap_n     = gap_cnt_q + ISI_W'(1);
          end
          spk_cnt_d = spk_n;
          gap_cnt_d = gap_n;
          gap_ovf_d = gap_ovf_n;
          isi_d     = isi_n;
          seen_d    = seen_n;
          sat_d     = sat_n;
          win_cnt_d = win_cnt_q + WIN_W'(1);
          if (win_cnt_q == len_q - WIN_W'(1)) begin
            state_d  = S_HOLD;
            rate_o_d = spk_n;
            isi_o_d  = isi_n;
            sat_o_d  = sat_n;
            valid_d  = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (bus.rate_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
          do_start = start_ok;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_start) begin
      state_d   = S_COUNT;
      len_d     = bus.window_len;
      win_cnt_d = '0;
      spk_cnt_d = '0;
      gap_cnt_d = '0;
      gap_ovf_d = 1'b0;
      isi_d     = '0;
      seen_d    = 1'b0;
      sat_d     = 1'b0;
    end
  end

  assign bus.rate_out   = rate_o_q;
  assign bus.isi_out    = isi_o_q;
  assign bus.sat        = sat_o_q;
  assign bus.rate_valid = valid_q;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboarded bench for spike_rate_decoder: default widths plus a CNT_W=4 instance.
module tb_spike_rate_decoder;
  typedef struct packed {
    logic [7:0] rate;
    logic [7:0] isi;
    logic       sat;
  } res_t;

  logic clk, rst_n;
  int   n_chk, n_err;
  res_t sb[$];
  res_t e;

  spike_rate_decoder_if #(.WIN_W(8), .CNT_W(8), .ISI_W(8)) d  ();
  spike_rate_decoder_if #(.WIN_W(8), .CNT_W(4), .ISI_W(8)) d4 ();

  spike_rate_decoder #(.WIN_W(8), .CNT_W(8), .ISI_W(8)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(d));
  spike_rate_decoder #(.WIN_W(8), .CNT_W(4), .ISI_W(8)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(d4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference decode of one window (default widths, no HOLD effects).
  function automatic res_t model(input int n, input logic [255:0] pat);
    res_t r;
    int   last;
    bit   seen;
    r = '0; last = 0; seen = 0;
    for (int i = 0; i < n; i++) begin
      if (pat[i]) begin
        if (r.rate == 8'hFF) r.sat = 1'b1;
        else                 r.rate = r.rate + 8'd1;
        if (seen) r.isi = 8'(i - last);
        last = i;
        seen = 1;
      end
    end
    return r;
  endfunction

  // Result handshake happens on the next edge: compare against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && d.rate_valid && d.rate_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rate", 32'(d.rate_out), 32'(e.rate));
        chk("isi",  32'(d.isi_out),  32'(e.isi));
        chk("sat",  32'(d.sat),      32'(e.sat));
      end
    end
  end

  // Drives N samples; from_idle adds the IDLE start cycle first.
  task automatic run_win(input int n, input logic [255:0] pat, input bit from_idle);
    d.window_len = 8'(n);
    d.ena = 1'b1;
    if (from_idle) begin
      d.spike_in = 1'b0;
      cyc();
    end
    for (int i = 0; i < n; i++) begin
      d.spike_in = pat[i];
      if (i == n - 1) chk("vld_early", 32'(d.rate_valid), 32'd0);
      cyc();
    end
    d.spike_in = 1'b0;
    chk("vld_latency", 32'(d.rate_valid), 32'd1);
  endtask

  task automatic end_win();
    d.ena = 1'b0;
    cyc();
    chk("vld_drop", 32'(d.rate_valid), 32'd0);
  endtask

  initial begin
    logic [255:0] p, p2;
    int           n, n2, vseen;
    logic [7:0]   r0, i0;
    logic         s0;
    n_chk = 0; n_err = 0;
    rst_n = 1'b0;
    d.ena = 1'b0; d.spike_in = 1'b0; d.window_len = '0; d.rate_ready = 1'b0;
    d4.ena = 1'b0; d4.spike_in = 1'b0; d4.window_len = '0; d4.rate_ready = 1'b0;
    cyc(); cyc();
    chk("rst_valid", 32'(d.rate_valid), 32'd0);
    chk("rst_rate",  32'(d.rate_out),   32'd0);
    chk("rst_isi",   32'(d.isi_out),    32'd0);
    chk("rst_sat",   32'(d.sat),        32'd0);
    rst_n = 1'b1;
    cyc();

    // 4-bit count saturates at 15 and flags sat
    d4.window_len = 8'd20; d4.ena = 1'b1; d4.spike_in = 1'b1; d4.rate_ready = 1'b1;
    repeat (21) cyc();
    chk("c4_valid", 32'(d4.rate_valid), 32'd1);
    chk("c4_rate",  32'(d4.rate_out),   32'd15);
    chk("c4_isi",   32'(d4.isi_out),    32'd1);
    chk("c4_sat",   32'(d4.sat),        32'd1);
    d4.ena = 1'b0; d4.spike_in = 1'b0;
    cyc();
    chk("c4_drop",  32'(d4.rate_valid), 32'd0);

    // basic window: spikes at 0,3,9 of N=10
    d.rate_ready = 1'b1;
    p = '0; p[0] = 1'b1; p[3] = 1'b1; p[9] = 1'b1;
    sb.push_back('{rate: 8'd3, isi: 8'd6, sat: 1'b0});
    run_win(10, p, 1'b1);
    end_win();

    // backpressure with spikes during HOLD, then a back-to-back window
    d.rate_ready = 1'b0;
    p = '0; p[3:0] = 4'hF;
    sb.push_back('{rate: 8'd4, isi: 8'd1, sat: 1'b0});
    run_win(4, p, 1'b1);
    for (int i = 0; i < 5; i++) begin
      d.spike_in = 1'b1;
      cyc();
      chk("bp_valid", 32'(d.rate_valid), 32'd1);
      chk("bp_rate",  32'(d.rate_out),   32'd4);
      chk("bp_isi",   32'(d.isi_out),    32'd1);
    end
    d.spike_in = 1'b0; d.rate_ready = 1'b1;
    p = '0; p[0] = 1'b1; p[2] = 1'b1;
    sb.push_back('{rate: 8'd2, isi: 8'd2, sat: 1'b0});
    cyc();
    chk("bp_hs_drop", 32'(d.rate_valid), 32'd0);
    run_win(4, p, 1'b0);
    end_win();

    // exact 255 count does not saturate; long ISI of 254
    sb.push_back('{rate: 8'd255, isi: 8'd1, sat: 1'b0});
    run_win(255, '1, 1'b1);
    end_win();
    p = '0; p[0] = 1'b1; p[254] = 1'b1;
    sb.push_back('{rate: 8'd2, isi: 8'd254, sat: 1'b0});
    run_win(255, p, 1'b1);
    end_win();

    // abort at COUNT cycle 5 of N=8
    d.window_len = 8'd8; d.ena = 1'b1; d.spike_in = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      d.spike_in = 1'b1;
      cyc();
    end
    d.ena = 1'b0;
    vseen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      d.spike_in = 1'b0;
      if (d.rate_valid) vseen++;
    end
    chk("abort_novalid", 32'(vseen), 32'd0);
    chk("abort_rate",    32'(d.rate_out), 32'd2);
    chk("abort_isi",     32'(d.isi_out),  32'd254);

    // zero-length window holds in IDLE
    d.window_len = 8'd0; d.ena = 1'b1;
    vseen = 0;
    for (int i = 0; i < 20; i++) begin
      d.spike_in = 1'($urandom_range(0, 1));
      cyc();
      if (d.rate_valid) vseen++;
    end
    chk("zero_novalid", 32'(vseen), 32'd0);
    p = '0; p[0] = 1'b1;
    sb.push_back('{rate: 8'd1, isi: 8'd0, sat: 1'b0});
    run_win(1, p, 1'b1);
    end_win();

    // back-to-back random windows, length changed during HOLD
    n = $urandom_range(2, 12);
    p = '0; p[31:0] = $urandom;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(model(n, p));
      run_win(n, p, k == 0);
      n2 = $urandom_range(2, 12);
      p2 = '0; p2[31:0] = $urandom;
      d.window_len = 8'(n2);
      d.spike_in = 1'b1;
      if (k == 2) d.ena = 1'b0;
      cyc();
      d.spike_in = 1'b0;
      chk("b2b_drop", 32'(d.rate_valid), 32'd0);
      n = n2; p = p2;
    end

    // reset while a result is pending
    d.rate_ready = 1'b0;
    p = '0; p[1] = 1'b1; p[4] = 1'b1; p[5] = 1'b1;
    run_win(6, p, 1'b1);
    r0 = d.rate_out; i0 = d.isi_out; s0 = d.sat;
    chk("pre_rst_rate", 32'(r0), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(d.rate_valid), 32'd0);
    chk("mid_rst_rate",  32'(d.rate_out),   32'd0);
    chk("mid_rst_isi",   32'(d.isi_out),    32'd0);
    chk("mid_rst_sat",   32'(d.sat),        32'd0);
    d.ena = 1'b0; d.rate_ready = 1'b1;
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("post_rst_idle", 32'(d.rate_valid), 32'd0);
    p = '0; p[0] = 1'b1; p[1] = 1'b1;
    sb.push_back('{rate: 8'd2, isi: 8'd1, sat: 1'b0});
    run_win(3, p, 1'b1);
    end_win();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
